// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Fetch stage in front of the single-cycle control unit. It owns the
// architectural PC, fetches one instruction at a time from the instruction
// SRAM over a req/gnt/rvalid bus, and presents {pc, inst} to the control unit
// under a valid/ready handshake. On retire the control unit's next_pc is
// sampled. A misaligned next_pc or a missing SRAM response halts fetch
// until reset.
//
// Parameters
//   RESET_PC     PC loaded on reset; address of the first fetch
//   TIMEOUT      WAIT cycles allowed for rvalid before bus_err (>= 1)
//
// Ports
//   clk          in   1   clock, all state changes on the rising edge
//   reset        in   1   asynchronous active-low reset
//   inst_req     out  1   fetch request to the instruction SRAM
//   inst_addr    out  32  fetch address, always equal to pc
//   inst_gnt     in   1   SRAM accepts the request this cycle
//   inst_rvalid  in   1   inst_rdata is valid this cycle
//   inst_rdata   in   32  fetched instruction word
//   pc           out  32  PC of the instruction being fetched / presented
//   inst         out  32  instruction word presented to the control unit
//   inst_valid   out  1   {pc, inst} valid for execution
//   inst_ready   in   1   control unit retires the instruction this cycle
//   next_pc      in   32  next PC from the control unit, sampled on retire
//   adel         out  1   sticky: retired with a misaligned next_pc
//   bus_err      out  1   sticky: rvalid not seen within TIMEOUT cycles
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_gnt,
   input  logic        inst_rvalid,
   input  logic [31:0] inst_rdata,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic [31:0] next_pc,
   output logic        adel,
   output logic        bus_err
);

   // Counter wide enough to hold the value TIMEOUT itself.
   localparam int unsigned       CNT_W       = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_inc;
   logic             wait_expired;
   logic             misaligned;

   assign wait_cnt_inc = wait_cnt + CNT_W'(1);
   // True in the WAIT cycle that would be the TIMEOUT-th without rvalid.
   assign wait_expired = (wait_cnt_inc == TIMEOUT_CNT);
   assign misaligned   = (next_pc[1:0] != 2'b00);

   // The address bus is the PC register itself, so it is stable for as long
   // as the request is held and has no path from any input.
   assign inst_addr = pc;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded outputs; outputs depend on state only.
   always_comb begin
      state_nxt  = state;
      inst_req   = 1'b0;
      inst_valid = 1'b0;
      case (state)
         S_IDLE: begin
            state_nxt = S_REQ;
         end
         S_REQ: begin
            inst_req = 1'b1;
            if (inst_gnt) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (inst_rvalid) begin
               state_nxt = S_HOLD;
            end else if (wait_expired) begin
               state_nxt = S_ERR;
            end
         end
         S_HOLD: begin
            inst_valid = 1'b1;
            if (inst_ready) begin
               state_nxt = misaligned ? S_ERR : S_REQ;
            end
         end
         S_ERR: begin
            // Terminal until reset.
            state_nxt = S_ERR;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // PC, instruction latch, WAIT counter and sticky error flags.
   // gnt outside REQ, rvalid outside WAIT and ready outside HOLD fall into
   // the default arm and are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc       <= RESET_PC;
         inst     <= 32'h0;
         wait_cnt <= '0;
         adel     <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (inst_gnt) begin
                  wait_cnt <= '0;
               end
            end
            S_WAIT: begin
               if (inst_rvalid) begin
                  inst <= inst_rdata;
               end else begin
                  wait_cnt <= wait_cnt_inc;
                  if (wait_expired) begin
                     bus_err <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  // A misaligned target leaves pc on the faulting instruction.
                  if (misaligned) begin
                     adel <= 1'b1;
                  end else begin
                     pc <= next_pc;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Directed bench for inst_fetch_unit. Stimulus pushes the expected fetch
// address of every SRAM handshake and the expected {pc, inst} of every
// retire into queues; two monitors pop and compare whenever the DUT shows a
// req/gnt or valid/ready handshake. Cycle-level behaviour (latency, stall
// stability, error flags, reset values) is checked inline.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;
   localparam int          TMO    = 16;

   logic        clk         = 1'b0;
   logic        reset       = 1'b0;
   logic        inst_gnt    = 1'b0;
   logic        inst_rvalid = 1'b0;
   logic        inst_ready  = 1'b0;
   logic [31:0] inst_rdata  = 32'h0;
   logic [31:0] next_pc     = 32'h0;
   logic        inst_req;
   logic        inst_valid;
   logic        adel;
   logic        bus_err;
   logic [31:0] inst_addr;
   logic [31:0] pc;
   logic [31:0] inst;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] addr_q[$];
   logic [63:0] ret_q[$];
   logic [63:0] ret_e;

   inst_fetch_unit #(
      .RESET_PC (RST_PC),
      .TIMEOUT  (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_gnt    (inst_gnt),
      .inst_rvalid (inst_rvalid),
      .inst_rdata  (inst_rdata),
      .pc          (pc),
      .inst        (inst),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .next_pc     (next_pc),
      .adel        (adel),
      .bus_err     (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Fetch-address monitor: every accepted request must match the queue.
   always @(negedge clk) begin
      if (reset && inst_req && inst_gnt) begin
         if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetch actual=%h required=none", inst_addr);
         end else begin
            chk("fetch_addr", inst_addr, addr_q.pop_front());
         end
      end
   end

   // Retire monitor: every valid/ready handshake must match the queue.
   always @(negedge clk) begin
      if (reset && inst_valid && inst_ready) begin
         if (ret_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_retire actual=%h required=none", pc);
         end else begin
            ret_e = ret_q.pop_front();
            chk("retire_pc", pc, ret_e[63:32]);
            chk("retire_inst", inst, ret_e[31:0]);
         end
      end
   end

   task automatic chk_reset(input string name);
      chk({name, "_req"},     32'(inst_req),   32'd0);
      chk({name, "_valid"},   32'(inst_valid), 32'd0);
      chk({name, "_pc"},      pc,              RST_PC);
      chk({name, "_addr"},    inst_addr,       RST_PC);
      chk({name, "_inst"},    inst,            32'h0);
      chk({name, "_adel"},    32'(adel),       32'd0);
      chk({name, "_bus_err"}, 32'(bus_err),    32'd0);
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!inst_req && n < 20) begin
         tick();
         n++;
      end
      chk({name, "_req_seen"}, 32'(inst_req), 32'd1);
   endtask

   // One complete fetch: gnt after gnt_dly stalled cycles, rvalid after
   // rv_dly WAIT cycles. Leaves the DUT in HOLD.
   task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] data,
                        input int gnt_dly, input int rv_dly);
      int reqc = 0;
      addr_q.push_back(addr);
      wait_req(name);
      for (int i = 0; i < gnt_dly; i++) begin
         if (inst_req && inst_addr == addr) reqc++;
         tick();
      end
      if (inst_req && inst_addr == addr) reqc++;
      inst_gnt = 1'b1;
      tick();
      inst_gnt = 1'b0;
      chk({name, "_req_cycles"}, 32'(reqc), 32'(gnt_dly + 1));
      chk({name, "_req_drop"}, 32'(inst_req), 32'd0);
      for (int i = 0; i < rv_dly; i++) tick();
      inst_rdata  = data;
      inst_rvalid = 1'b1;
      tick();
      inst_rvalid = 1'b0;
      inst_rdata  = 32'h0;
      chk({name, "_valid"}, 32'(inst_valid), 32'd1);
      chk({name, "_inst"}, inst, data);
      chk({name, "_pc"}, pc, addr);
   endtask

   task automatic retire(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_inst,
                         input logic [31:0] npc);
      int n = 0;
      while (!inst_valid && n < 20) begin
         tick();
         n++;
      end
      chk({name, "_ready_valid"}, 32'(inst_valid), 32'd1);
      ret_q.push_back({exp_pc, exp_inst});
      next_pc    = npc;
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk({name, "_valid_drop"}, 32'(inst_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk_reset("rst0");

      // 1: release, gnt with the first req, rvalid one cycle later
      addr_q.push_back(RST_PC);
      reset = 1'b1;
      tick();
      chk("t1_req", 32'(inst_req), 32'd1);
      chk("t1_addr", inst_addr, RST_PC);
      chk("t1_valid_c1", 32'(inst_valid), 32'd0);
      inst_gnt = 1'b1;
      tick();
      inst_gnt = 1'b0;
      chk("t1_wait_req", 32'(inst_req), 32'd0);
      chk("t1_valid_c2", 32'(inst_valid), 32'd0);
      inst_rdata  = 32'h2408_0005;
      inst_rvalid = 1'b1;
      tick();
      inst_rvalid = 1'b0;
      inst_rdata  = 32'h0;
      chk("t1_valid_c3", 32'(inst_valid), 32'd1);
      chk("t1_inst", inst, 32'h2408_0005);
      chk("t1_pc", pc, RST_PC);
      retire("t1", RST_PC, 32'h2408_0005, 32'hBFC0_0004);
      chk("t1_next_req", 32'(inst_req), 32'd1);
      chk("t1_next_pc", pc, 32'hBFC0_0004);

      // 2: gnt delayed three cycles, request held for four
      fetch("t2", 32'hBFC0_0004, 32'h8C09_0010, 3, 2);

      // 3: stall in HOLD for five cycles, then advance exactly once
      next_pc = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_valid", 32'(inst_valid), 32'd1);
         chk("t3_pc", pc, 32'hBFC0_0004);
         chk("t3_inst", inst, 32'h8C09_0010);
         chk("t3_req", 32'(inst_req), 32'd0);
      end
      retire("t3", 32'hBFC0_0004, 32'h8C09_0010, 32'hBFC0_0100);
      chk("t3_adv_pc", pc, 32'hBFC0_0100);
      chk("t3_adv_req", 32'(inst_req), 32'd1);
      fetch("t3b", 32'hBFC0_0100, 32'h1000_FFFF, 1, 0);

      // 4: misaligned next_pc halts fetch with adel; ready/gnt then ignored
      retire("t4", 32'hBFC0_0100, 32'h1000_FFFF, 32'hBFC0_0012);
      chk("t4_adel", 32'(adel), 32'd1);
      chk("t4_bus_err", 32'(bus_err), 32'd0);
      inst_ready = 1'b1;
      inst_gnt   = 1'b1;
      next_pc    = 32'hBFC0_0200;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_req", 32'(inst_req), 32'd0);
         chk("t4_valid", 32'(inst_valid), 32'd0);
         chk("t4_pc", pc, 32'hBFC0_0100);
         chk("t4_adel_hold", 32'(adel), 32'd1);
      end
      inst_ready = 1'b0;
      inst_gnt   = 1'b0;

      reset = 1'b0;
      tick();
      chk_reset("t5_rst");
      reset = 1'b1;

      // 5: gnt, then no rvalid -> bus_err after TMO WAIT cycles
      addr_q.push_back(RST_PC);
      wait_req("t5");
      inst_gnt = 1'b1;
      tick();
      inst_gnt = 1'b0;
      for (int i = 1; i < TMO; i++) begin
         tick();
         chk("t5_no_err_yet", 32'(bus_err), 32'd0);
      end
      tick();
      chk("t5_bus_err", 32'(bus_err), 32'd1);
      chk("t5_req", 32'(inst_req), 32'd0);
      chk("t5_valid", 32'(inst_valid), 32'd0);
      inst_rdata  = 32'hDEAD_BEEF;
      inst_rvalid = 1'b1;
      tick();
      inst_rvalid = 1'b0;
      inst_rdata  = 32'h0;
      repeat (2) tick();
      chk("t5_late_inst", inst, 32'h0);
      chk("t5_late_valid", 32'(inst_valid), 32'd0);
      chk("t5_late_err", 32'(bus_err), 32'd1);
      chk("t5_late_req", 32'(inst_req), 32'd0);

      // 6: asynchronous reset while in WAIT, then restart from RESET_PC
      reset = 1'b0;
      tick();
      reset = 1'b1;
      fetch("t6a", RST_PC, 32'h3C01_BFC0, 0, 0);
      retire("t6a", RST_PC, 32'h3C01_BFC0, 32'hBFC0_0040);
      addr_q.push_back(32'hBFC0_0040);
      wait_req("t6w");
      inst_gnt = 1'b1;
      tick();
      inst_gnt = 1'b0;
      chk("t6_pre_pc", pc, 32'hBFC0_0040);
      chk("t6_pre_inst", inst, 32'h3C01_BFC0);
      #2;
      reset = 1'b0;
      #1;
      chk_reset("t6_async");
      tick();
      reset = 1'b1;
      fetch("t6b", RST_PC, 32'h2409_0007, 0, 1);
      retire("t6b", RST_PC, 32'h2409_0007, 32'hBFC0_0004);

      repeat (3) tick();
      chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
      chk("ret_q_empty", 32'(ret_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
